// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 constants, sequencer state encoding and access-size decode
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    typedef struct packed {
        logic [2:0] n;
        logic       sgn;
        logic       legal;
    } size_t;

    // Unsigned variants exist only for loads.
    function automatic size_t size_decode(input logic [2:0] f3, input logic wr);
        size_t s;
        s.n     = (f3[1:0] == 2'b00) ? 3'd1 : (f3[1:0] == 2'b01) ? 3'd2 : 3'd4;
        s.sgn   = ~f3[2];
        s.legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                  (!wr && ((f3 == F3_BU) || (f3 == F3_HU)));
        return s;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte-lane masks, split detect, store scatter and load merge/extend
//   ofs/n/sgn     : byte offset, access size in bytes, sign-extend flag
//   wdata, r0, r1 : store data, first and second captured read words
//   be0/be1, split: lane enables per word, access crosses a word boundary
//   wd0/wd1, rdata: lane-positioned store words, extended load result
module lsu_lane_align (
    input  logic [1:0]  ofs,
    input  logic [2:0]  n,
    input  logic        sgn,
    input  logic [31:0] wdata,
    input  logic [31:0] r0,
    input  logic [31:0] r1,
    output logic [3:0]  be0,
    output logic [3:0]  be1,
    output logic        split,
    output logic [31:0] wd0,
    output logic [31:0] wd1,
    output logic [31:0] rdata
);

    logic [7:0]  m;
    logic [63:0] d64;
    logic [31:0] x;

    always_comb begin
        m     = {4'b0000, 4'((5'd1 << n) - 5'd1)} << ofs;
        be0   = m[3:0];
        be1   = m[7:4];
        split = |m[7:4];
        d64   = {32'b0, wdata} << {ofs, 3'b000};
        wd0   = d64[31:0];
        wd1   = d64[63:32];
        x     = 32'({r1, r0} >> {ofs, 3'b000});
        rdata = (n == 3'd1) ? {{24{sgn & x[7]}}, x[7:0]} :
                (n == 3'd2) ? {{16{sgn & x[15]}}, x[15:0]} : x;
    end

endmodule

// File: rtl/lsu_sequencer.sv
// lsu_sequencer: one-at-a-time load/store controller issuing aligned bus words
//   clk_i, rst_i          : clock, synchronous active-high reset
//   req_i .. wdata_i      : memory-stage request (read/write, funct3, address, data)
//   busy_o, done_o, err_o : stall, completion pulse, error flag valid with done_o
//   rdata_o               : extended load result valid with done_o
//   bus_*                 : word-aligned bus transaction, held until bus_ack_i
module lsu_sequencer
    import lsu_pkg::*;
#(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct_3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    state_t      state, state_n;
    size_t       sz;
    logic [31:0] addr_q, wdata_q, r0_q, r1_q, word0, wd0, wd1, ld_data;
    logic [2:0]  n_q;
    logic [3:0]  be0, be1;
    logic        sgn_q, we_q, err_q, split, split_in, bad, active;

    assign sz       = size_decode(funct_3_i, mem_write_i);
    assign split_in = ({1'b0, addr_i[1:0]} + sz.n) > 3'd4;
    assign bad      = (mem_read_i == mem_write_i) || !sz.legal || (split_in && !SPLIT_EN);
    assign word0    = {addr_q[31:2], 2'b00};

    lsu_lane_align u_align (
        .ofs   (addr_q[1:0]),
        .n     (n_q),
        .sgn   (sgn_q),
        .wdata (wdata_q),
        .r0    (r0_q),
        .r1    (r1_q),
        .be0   (be0),
        .be1   (be1),
        .split (split),
        .wd0   (wd0),
        .wd1   (wd1),
        .rdata (ld_data)
    );

    always_ff @(posedge clk_i) begin
        state <= rst_i ? IDLE : state_n;
    end

    always_comb begin
        state_n = (state == IDLE) ? (req_i ? (bad ? RESP : ACC0) : IDLE) :
                  (state == ACC0) ? (bus_ack_i ? (split ? ACC1 : RESP) : ACC0) :
                  (state == ACC1) ? (bus_ack_i ? RESP : ACC1) : IDLE;
        active      = (state == ACC0) || (state == ACC1);
        busy_o      = state != IDLE;
        done_o      = state == RESP;
        err_o       = done_o && err_q;
        rdata_o     = (done_o && !we_q && !err_q) ? ld_data : '0;
        bus_req_o   = active;
        bus_we_o    = active && we_q;
        bus_addr_o  = (state == ACC0) ? word0 : (state == ACC1) ? word0 + 32'd4 : '0;
        bus_be_o    = (state == ACC0) ? be0 : (state == ACC1) ? be1 : '0;
        bus_wdata_o = !bus_we_o ? '0 : (state == ACC1) ? wd1 : wd0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            wdata_q <= '0;
            n_q     <= '0;
            sgn_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            r0_q    <= '0;
            r1_q    <= '0;
        end else begin
            if (state == IDLE && req_i) begin
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                n_q     <= sz.n;
                sgn_q   <= sz.sgn;
                we_q    <= mem_write_i;
                err_q   <= bad;
            end
            // r1 is cleared on the first word so a non-split merge sees zeros above r0.
            if (state == ACC0 && bus_ack_i) begin
                r0_q <= bus_rdata_i;
                r1_q <= '0;
            end
            if (state == ACC1 && bus_ack_i)
                r1_q <= bus_rdata_i;
        end
    end

endmodule

// File: tb/tb_lsu_sequencer.sv
// tb_lsu_sequencer: directed table-driven check of lsu_sequencer with split enabled and disabled
module tb_lsu_sequencer;

    typedef struct {
        logic        wr, rd;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, r0, r1;
        int          waits;
        logic        err, split;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [31:0] wd0, a1;
        logic [3:0]  be1;
        logic [31:0] wd1, exp_rd;
    } vec_t;

    logic        clk = 1'b0, rst = 1'b0, req = 1'b0, rd = 1'b0, wr = 1'b0, ack = 1'b0;
    logic [2:0]  f3 = '0;
    logic [31:0] addr = '0, wdata = '0, bus_rd = '0;
    logic        busy, done, err, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        busy0, done0, err0, bus_req0, bus_we0;
    logic [31:0] rdata0, bus_addr0, bus_wdata0;
    logic [3:0]  bus_be0;
    int          checks = 0, errors = 0;
    vec_t        vecs [13];

    always #5 clk = ~clk;

    lsu_sequencer #(.SPLIT_EN(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .mem_read_i(rd), .mem_write_i(wr),
        .funct_3_i(f3), .addr_i(addr), .wdata_i(wdata), .busy_o(busy), .done_o(done),
        .err_o(err), .rdata_o(rdata), .bus_req_o(bus_req), .bus_we_o(bus_we),
        .bus_addr_o(bus_addr), .bus_be_o(bus_be), .bus_wdata_o(bus_wdata),
        .bus_ack_i(ack), .bus_rdata_i(bus_rd)
    );

    lsu_sequencer #(.SPLIT_EN(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .mem_read_i(rd), .mem_write_i(wr),
        .funct_3_i(f3), .addr_i(addr), .wdata_i(wdata), .busy_o(busy0), .done_o(done0),
        .err_o(err0), .rdata_o(rdata0), .bus_req_o(bus_req0), .bus_we_o(bus_we0),
        .bus_addr_o(bus_addr0), .bus_be_o(bus_be0), .bus_wdata_o(bus_wdata0),
        .bus_ack_i(ack), .bus_rdata_i(bus_rd)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic string id(input int i, input string nm);
        return $sformatf("v%0d %s", i, nm);
    endfunction

    task automatic run(input int i, input vec_t v);
        int cyc;
        logic [31:0] ea;
        req = 1'b1; rd = v.rd; wr = v.wr; f3 = v.f3; addr = v.addr; wdata = v.wdata;
        tick();
        req = 1'b0;
        cyc = 1;
        chk(id(i, "busy"), busy, 1);
        if (v.err || v.split) begin
            chk(id(i, "nosplit done"), done0, 1);
            chk(id(i, "nosplit err"), err0, 1);
            chk(id(i, "nosplit bus_req"), bus_req0, 0);
        end else
            chk(id(i, "nosplit bus_req"), bus_req0, 1);
        if (v.err) begin
            chk(id(i, "err done"), done, 1);
            chk(id(i, "err flag"), err, 1);
            chk(id(i, "err bus_req"), bus_req, 0);
            chk(id(i, "err rdata"), rdata, 0);
        end else begin
            for (int p = 0; p < (v.split ? 2 : 1); p++) begin
                ea = (p == 1) ? v.a1 : v.a0;
                chk(id(i, $sformatf("p%0d bus_req", p)), bus_req, 1);
                chk(id(i, $sformatf("p%0d addr", p)), bus_addr, ea);
                chk(id(i, $sformatf("p%0d be", p)), bus_be, (p == 1) ? v.be1 : v.be0);
                chk(id(i, $sformatf("p%0d we", p)), bus_we, v.wr);
                chk(id(i, $sformatf("p%0d wdata", p)), bus_wdata, (p == 1) ? v.wd1 : v.wd0);
                repeat (v.waits) begin
                    tick();
                    cyc++;
                    chk(id(i, "wait bus_req"), bus_req, 1);
                    chk(id(i, "wait addr"), bus_addr, ea);
                    chk(id(i, "wait done"), done, 0);
                end
                ack = 1'b1;
                bus_rd = (p == 1) ? v.r1 : v.r0;
                tick();
                cyc++;
                ack = 1'b0;
                bus_rd = 32'h5A5A_5A5A;
            end
            chk(id(i, "done"), done, 1);
            chk(id(i, "err"), err, 0);
            chk(id(i, "rdata"), rdata, v.exp_rd);
            chk(id(i, "bus_req in resp"), bus_req, 0);
            chk(id(i, "latency"), cyc, v.split ? 3 + 2 * v.waits : 2 + v.waits);
        end
        tick();
        chk(id(i, "done pulse"), done, 0);
        chk(id(i, "idle"), busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //           wr rd f3      addr          wdata         r0            r1            w  err sp a0            be0     wd0           a1            be1     wd1           exp_rd
        vecs[0]  = '{1, 0, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        32'h0,        0, 0, 0, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0,        4'b0000, 32'h0,        32'h0};
        vecs[1]  = '{0, 1, 3'b000, 32'h0000_0203, 32'h0,        32'h80FF_FFFF, 32'h0,        4, 0, 0, 32'h0000_0200, 4'b1000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hFFFF_FF80};
        vecs[2]  = '{0, 1, 3'b010, 32'h0000_01FE, 32'h0,        32'hAABB_1122, 32'h3344_CCDD, 0, 0, 1, 32'h0000_01FC, 4'b1100, 32'h0,        32'h0000_0200, 4'b0011, 32'h0,        32'hCCDD_AABB};
        vecs[3]  = '{1, 0, 3'b001, 32'h0000_00FF, 32'h0000_1234, 32'h0,        32'h0,        1, 0, 1, 32'h0000_00FC, 4'b1000, 32'h3400_0000, 32'h0000_0100, 4'b0001, 32'h0000_0012, 32'h0};
        vecs[4]  = '{0, 1, 3'b011, 32'h0000_0100, 32'h0,        32'h0,        32'h0,        0, 1, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0};
        vecs[5]  = '{0, 1, 3'b010, 32'hFFFF_FFFF, 32'h0,        32'h1122_3344, 32'h5566_7788, 0, 0, 1, 32'hFFFF_FFFC, 4'b1000, 32'h0,        32'h0000_0000, 4'b0111, 32'h0,        32'h6677_8811};
        vecs[6]  = '{0, 1, 3'b101, 32'h0000_0002, 32'h0,        32'h8001_0000, 32'h0,        1, 0, 0, 32'h0000_0000, 4'b1100, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0000_8001};
        vecs[7]  = '{0, 1, 3'b001, 32'h0000_0002, 32'h0,        32'h8001_0000, 32'h0,        0, 0, 0, 32'h0000_0000, 4'b1100, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hFFFF_8001};
        vecs[8]  = '{1, 0, 3'b000, 32'h0000_0001, 32'h0000_00AB, 32'h0,        32'h0,        0, 0, 0, 32'h0000_0000, 4'b0010, 32'h0000_AB00, 32'h0,        4'b0000, 32'h0,        32'h0};
        vecs[9]  = '{1, 1, 3'b010, 32'h0000_0100, 32'h0,        32'h0,        32'h0,        0, 1, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0};
        vecs[10] = '{1, 0, 3'b100, 32'h0000_0100, 32'h0000_0055, 32'h0,        32'h0,        0, 1, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0};
        vecs[11] = '{0, 1, 3'b001, 32'h0000_0001, 32'h0,        32'h00AB_CD00, 32'h0,        2, 0, 0, 32'h0000_0000, 4'b0110, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hFFFF_ABCD};
        vecs[12] = '{0, 1, 3'b100, 32'h0000_0000, 32'h0,        32'h0000_00F0, 32'h0,        0, 0, 0, 32'h0000_0000, 4'b0001, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0000_00F0};

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset err", err, 0);
        chk("reset rdata", rdata, 0);
        chk("reset bus_req", bus_req, 0);
        chk("reset bus_we", bus_we, 0);
        chk("reset bus_addr", bus_addr, 0);
        chk("reset bus_be", bus_be, 0);
        chk("reset bus_wdata", bus_wdata, 0);

        for (int i = 0; i < 13; i++)
            run(i, vecs[i]);

        req = 1'b1; rd = 1'b1; wr = 1'b0; f3 = 3'b010; addr = 32'h0000_0300;
        tick();
        req = 1'b0;
        chk("rst-mid bus_req", bus_req, 1);
        tick();
        chk("rst-mid still waiting", bus_req, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst-mid bus_req dropped", bus_req, 0);
        chk("rst-mid busy", busy, 0);
        chk("rst-mid done", done, 0);
        ack = 1'b1;
        bus_rd = 32'h1234_5678;
        tick();
        ack = 1'b0;
        chk("late ack busy", busy, 0);
        chk("late ack done", done, 0);
        chk("late ack bus_req", bus_req, 0);
        run(13, vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
